// File: rtl/bp_fe_bht_update_gen.sv
// BHT training write generator: queues predictions in order and
// emits one registered BHT update per resolved branch.
module bp_fe_bht_update_gen #(
  parameter int bht_idx_width_p = 9,
  parameter int fifo_els_p      = 8,
  parameter int cnt_width_p     = 16,
  localparam int ptr_w_lp = $clog2(fifo_els_p),
  localparam int cnt_w_lp = ptr_w_lp + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  output logic                       pred_ready_o,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [cnt_w_lp-1:0]        inflight_o,
  output logic [cnt_width_p-1:0]     mispredict_cnt_o,
  output logic                       underflow_o
);

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       taken;
  } entry_t;

  localparam logic [cnt_w_lp-1:0] full_lp =
    cnt_w_lp'(fifo_els_p);

  entry_t                     mem_q [fifo_els_p];
  entry_t                     wdata_d;
  entry_t                     head;
  logic [ptr_w_lp-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]        rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
  logic                       correct_q, correct_d;
  logic [cnt_width_p-1:0]     mis_q, mis_d;
  logic                       uf_q, uf_d;
  logic                       enq, deq, empty, hit;

  assign empty        = (cnt_q == '0);
  assign pred_ready_o = (cnt_q != full_lp);
  assign enq          = pred_v_i & pred_ready_o & ~flush_i;
  assign deq          = res_v_i & ~empty;
  assign head         = mem_q[rd_ptr_q];
  assign hit          = (head.taken == res_taken_i);

  always_comb begin
    wdata_d   = '{idx: pred_idx_i, taken: pred_taken_i};
    wr_ptr_d  = wr_ptr_q + ptr_w_lp'(enq);
    rd_ptr_d  = rd_ptr_q + ptr_w_lp'(deq);
    cnt_d     = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    w_v_d     = deq;
    idx_w_d   = idx_w_q;
    correct_d = correct_q;
    mis_d     = mis_q;
    uf_d      = uf_q | (res_v_i & empty);
    if (deq) begin
      idx_w_d   = head.idx;
      correct_d = hit;
      if (!hit && mis_q != '1)
        mis_d = mis_q + 1'b1;
    end
    // a flush retires the same-cycle resolve, then drops the rest
    if (flush_i) begin
      rd_ptr_d = wr_ptr_d;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_q[wr_ptr_q] <= wdata_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      w_v_q     <= 1'b0;
      idx_w_q   <= '0;
      correct_q <= 1'b0;
      mis_q     <= '0;
      uf_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      w_v_q     <= w_v_d;
      idx_w_q   <= idx_w_d;
      correct_q <= correct_d;
      mis_q     <= mis_d;
      uf_q      <= uf_d;
    end
  end

  assign w_v_o            = w_v_q;
  assign idx_w_o          = idx_w_q;
  assign correct_o        = correct_q;
  assign inflight_o       = cnt_q;
  assign mispredict_cnt_o = mis_q;
  assign underflow_o      = uf_q;

endmodule
